game_control: RTL and testbench
===============================

Name: game_control

Overview:
- Control FSM for the memory game; sits directly upstream of the game datapath.
- Consumes the datapath status flags (end_FPGA, end_User, end_time, win, match) and the player's enter key.
- Drives the datapath resets R1/R2, enables E1–E4 and the display select SEL.
- Sequences the game through setup, sequence playback, user entry, check, next round and result display.

Parameters:
- DEBOUNCE_CYC, 500000, consecutive stable-low cycles needed to accept a key press (10 ms at 50 MHz); used only with DEBOUNCE_EN.

Ports:
- CLOCK_50 input 1: system clock, 50 MHz.
- reset input 1: synchronous, active-low reset.
- enter input 1: raw enter key (KEY[0]), active-low, asynchronous to CLOCK_50.
- end_FPGA input 1: FPGA sequence playback finished.
- end_User input 1: user finished entering the sequence.
- end_time input 1: user entry time expired.
- win input 1: final round reached.
- match input 1: user sequence equals FPGA sequence.
- R1 output 1: global datapath reset (setup, round counter, clock divider).
- R2 output 1: per-round datapath reset (time counter, FPGA counter, user/FPGA registers).
- E1 output 1: setup register load enable.
- E2 output 1: user entry / time counter enable.
- E3 output 1: FPGA sequence counter / register enable.
- E4 output 1: round counter increment.
- SEL output 1: display select; 1 = level/time/round, 0 = result/points.
- state_o output 3: current state encoding, for debug.

Behaviour:
- Moore FSM. Outputs decode from the registered state only. A transition condition sampled at edge N changes state and outputs at edge N.
- States, encodings and outputs (outputs not listed are 0):
  - INIT=0: R1=1, R2=1, SEL=1.
  - SETUP=1: E1=1, SEL=1.
  - PREP=2: R2=1, SEL=1.
  - SEQ=3: E3=1, SEL=1.
  - PLAY=4: E2=1, SEL=1.
  - CHECK=5: SEL=1.
  - NEXT=6: E4=1, SEL=1.
  - RESULT=7: SEL=0.
- Transitions:
  - INIT→SETUP: unconditionally, after one cycle.
  - SETUP→PREP: on press.
  - PREP→SEQ: after one cycle.
  - SEQ→PLAY: on end_FPGA.
  - PLAY→CHECK: on end_User. end_User has priority when end_User and end_time are asserted in the same cycle.
  - PLAY→RESULT: on end_time alone.
  - CHECK→RESULT: if !match, or if match && win.
  - CHECK→NEXT: if match && !win.
  - NEXT→PREP: after one cycle.
  - RESULT→INIT: on press.
- Presses in SEQ, PLAY, CHECK, PREP and NEXT are ignored. No press is queued.
- Key path:
  - 2-flop synchronizer, then a previous-value register.
  - press = prev & ~sync2, a one-cycle pulse on the high→low edge.
  - If enter is first sampled low at edge N, press is high during the cycle after edge N+1, so the state changes at edge N+2.
  - A held key gives exactly one pulse. Release gives no pulse.
- Reset:
  - reset low at any edge: state=INIT, sync/prev registers=1.
  - While reset is low, outputs equal the INIT outputs (R1=R2=1, SEL=1, E*=0, state_o=0).
  - Reset mid-round abandons the round immediately, with no partial enables.
- R1 and R2 are never asserted in the same cycle as any E*.

Optional Feature:
- Macro GAME_CONTROL_DEBOUNCE_EN.
- Defined:
  - A counter of width $clog2(DEBOUNCE_CYC+1) counts consecutive cycles with sync2=0, saturating at DEBOUNCE_CYC.
  - It clears to 0 whenever sync2=1.
  - press pulses exactly once, in the cycle the counter first reaches DEBOUNCE_CYC.
  - Glitches shorter than DEBOUNCE_CYC produce no press.
  - The counter resets to 0.
- Undefined: the raw synchronized edge detector above; no counter is instantiated.

Decomposition:
- Package game_pkg:
  - state typedef and 3-bit encodings INIT..RESULT.
  - DEBOUNCE_CYC default constant.
- One sub-module, key_pulse: synchronizer, edge detect and optional debounce counter; output is a single press pulse.
- game_control instantiates key_pulse and holds the FSM plus output decode.

Test Plan:
- Reset low for 3 cycles, then high, no key → INIT outputs (R1=1, R2=1, SEL=1, state_o=0) during reset; state_o=1, E1=1 one cycle after release.
- In SETUP, enter low for 10 cycles → exactly one press; state sequence 2 (R2=1 one cycle) then 3 (E3=1). No second transition while the key stays held.
- SEQ, end_FPGA=1 → PLAY (E2=1). end_User=1 with match=1, win=0 → CHECK, then NEXT (E4=1 for exactly 1 cycle), then PREP, then SEQ.
- PLAY with end_User=1 and end_time=1 in the same cycle, match=1, win=1 → CHECK then RESULT; SEL=0, all E*=0; enter press → INIT → SETUP.
- PLAY, end_time=1 only → RESULT next cycle. In CHECK with match=0 → RESULT. Reset low during SEQ → state_o=0, E3=0 at the next edge.
- With GAME_CONTROL_DEBOUNCE_EN and DEBOUNCE_CYC=4:
  - enter low 3 cycles then high → no transition from SETUP.
  - enter low 8 cycles → single transition to PREP, exactly 4 cycles after sync2 falls.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the memory-game control FSM.
// GAME_CONTROL_DEBOUNCE_EN selects the debounced key path in key_pulse.
package game_pkg;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        SETUP  = 3'd1,
        PREP   = 3'd2,
        SEQ    = 3'd3,
        PLAY   = 3'd4,
        CHECK  = 3'd5,
        NEXT   = 3'd6,
        RESULT = 3'd7
    } state_t;

    // 10 ms of stable-low key at 50 MHz
    localparam int DEBOUNCE_CYC_DEF = 500000;

endpackage

// File: rtl/key_pulse.sv
// Turns the raw active-low enter key into a single-cycle press pulse.
// Define GAME_CONTROL_DEBOUNCE_EN to require DEBOUNCE_CYC stable-low cycles.
module key_pulse
`ifdef GAME_CONTROL_DEBOUNCE_EN
    #(parameter int DEBOUNCE_CYC = game_pkg::DEBOUNCE_CYC_DEF)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic enter,
    output logic press
);

    logic sync_p1;
    logic sync_p2;

    // stage 1-2: two-flop synchronizer, idles high (key released)
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_p1 <= 1'b1;
            sync_p2 <= 1'b1;
        end else begin
            sync_p1 <= enter;
            sync_p2 <= sync_p1;
        end
    end

`ifdef GAME_CONTROL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DEBOUNCE_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // stage 3: consecutive-low counter, saturating so a held key fires once
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (sync_p2) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Fires in the cycle whose edge brings the counter to CNT_MAX
    assign press = ~sync_p2 & (cnt == CNT_ARM);
`else
    logic prev_p3;

    // stage 3: previous value for high-to-low edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_p3 <= 1'b1;
        end else begin
            prev_p3 <= sync_p2;
        end
    end

    assign press = prev_p3 & ~sync_p2;
`endif

endmodule

// File: rtl/game_control.sv
// Moore control FSM for the memory game: sequences rounds and drives datapath R/E/SEL.
// Define GAME_CONTROL_DEBOUNCE_EN to debounce the enter key (DEBOUNCE_CYC cycles).
module game_control
    import game_pkg::*;
`ifdef GAME_CONTROL_DEBOUNCE_EN
    #(parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF)
`endif
(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enter,
    input  logic       end_FPGA,
    input  logic       end_User,
    input  logic       end_time,
    input  logic       win,
    input  logic       match,
    output logic       R1,
    output logic       R2,
    output logic       E1,
    output logic       E2,
    output logic       E3,
    output logic       E4,
    output logic       SEL,
    output logic [2:0] state_o
);

    state_t state_q;
    state_t state_d;
    logic   press;

`ifdef GAME_CONTROL_DEBOUNCE_EN
    key_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
`else
    key_pulse u_key (
`endif
        .clk   (CLOCK_50),
        .reset (reset),
        .enter (enter),
        .press (press)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:   state_d = SETUP;
            SETUP:  if (press) state_d = PREP;
            PREP:   state_d = SEQ;
            SEQ:    if (end_FPGA) state_d = PLAY;
            // a finished entry wins over a simultaneous timeout
            PLAY: begin
                if (end_User)      state_d = CHECK;
                else if (end_time) state_d = RESULT;
            end
            CHECK:  state_d = (match && !win) ? NEXT : RESULT;
            NEXT:   state_d = PREP;
            RESULT: if (press) state_d = INIT;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        R1  = 1'b0;
        R2  = 1'b0;
        E1  = 1'b0;
        E2  = 1'b0;
        E3  = 1'b0;
        E4  = 1'b0;
        SEL = 1'b1;
        unique case (state_q)
            INIT:   begin R1 = 1'b1; R2 = 1'b1; end
            SETUP:  E1  = 1'b1;
            PREP:   R2  = 1'b1;
            SEQ:    E3  = 1'b1;
            PLAY:   E2  = 1'b1;
            CHECK:  ;
            NEXT:   E4  = 1'b1;
            RESULT: SEL = 1'b0;
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_game_control.sv
// Directed scoreboard bench for game_control: expected state per cycle is queued, a
// negedge monitor pops and compares the full output vector.
module tb_game_control;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       enter    = 1'b1;
    logic       end_FPGA = 1'b0;
    logic       end_User = 1'b0;
    logic       end_time = 1'b0;
    logic       win      = 1'b0;
    logic       match    = 1'b0;
    logic       R1, R2, E1, E2, E3, E4, SEL;
    logic [2:0] state_o;

`ifdef GAME_CONTROL_DEBOUNCE_EN
    localparam int LAT = 5;
    game_control #(.DEBOUNCE_CYC(4)) dut (
`else
    localparam int LAT = 2;
    game_control dut (
`endif
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .enter    (enter),
        .end_FPGA (end_FPGA),
        .end_User (end_User),
        .end_time (end_time),
        .win      (win),
        .match    (match),
        .R1       (R1),
        .R2       (R2),
        .E1       (E1),
        .E2       (E2),
        .E3       (E3),
        .E4       (E4),
        .SEL      (SEL),
        .state_o  (state_o)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [2:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    // {R1,R2,E1,E2,E3,E4,SEL,state_o} straight from the state output table
    function automatic logic [9:0] out_vec(input logic [2:0] s);
        logic [6:0] f;
        case (s)
            3'd0:    f = 7'b1100001;
            3'd1:    f = 7'b0010001;
            3'd2:    f = 7'b0100001;
            3'd3:    f = 7'b0000101;
            3'd4:    f = 7'b0001001;
            3'd5:    f = 7'b0000001;
            3'd6:    f = 7'b0000011;
            default: f = 7'b0000000;
        endcase
        return {f, s};
    endfunction

    always @(negedge CLOCK_50) begin
        if (exp_q.size() > 0) begin
            logic [2:0] e;
            logic [9:0] act;
            e   = exp_q.pop_front();
            act = {R1, R2, E1, E2, E3, E4, SEL, state_o};
            vectors++;
            if (act !== out_vec(e)) begin
                miscompares++;
                $display("FAIL outputs @%0t: got R1R2E1E2E3E4SEL=%b state=%0d, want %b state=%0d",
                         $time, act[9:3], act[2:0], out_vec(e)[9:3], e);
            end
        end
    end

    // One clock edge; queue the state expected right after it
    task automatic tick(input logic [2:0] s);
        @(posedge CLOCK_50);
        #1;
        exp_q.push_back(s);
    endtask

    // Hold the key for LAT+3 edges: s0 until the press lands, then a, b, c; release for 2 edges
    task automatic press_seq(input logic [2:0] s0, input logic [2:0] a,
                             input logic [2:0] b, input logic [2:0] c);
        enter = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            if (i < LAT)           tick(s0);
            else if (i == LAT)     tick(a);
            else if (i == LAT + 1) tick(b);
            else                   tick(c);
        end
        enter = 1'b1;
        tick(c);
        tick(c);
    endtask

    initial begin
        // reset held low: INIT outputs throughout
        for (int i = 0; i < 3; i++) tick(3'd0);
        reset = 1'b1;
        tick(3'd1);
        tick(3'd1);

`ifdef GAME_CONTROL_DEBOUNCE_EN
        // short glitch: 3 low cycles must not leave SETUP
        enter = 1'b0;
        for (int i = 0; i < 3; i++) tick(3'd1);
        enter = 1'b1;
        for (int i = 0; i < 4; i++) tick(3'd1);
`endif

        // 10-cycle hold: one press, PREP for one cycle, then SEQ and stay
        enter = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < LAT)       tick(3'd1);
            else if (i == LAT) tick(3'd2);
            else               tick(3'd3);
        end
        enter = 1'b1;
        tick(3'd3);
        tick(3'd3);

        // winning-so-far round: SEQ->PLAY->CHECK->NEXT->PREP->SEQ
        end_FPGA = 1'b1; tick(3'd4);
        end_FPGA = 1'b0;
        end_User = 1'b1; match = 1'b1; win = 1'b0; tick(3'd5);
        end_User = 1'b0;
        tick(3'd6);
        tick(3'd2);
        tick(3'd3);
        tick(3'd3);

        // press ignored in PLAY; then end_User and end_time together, final round
        end_FPGA = 1'b1; tick(3'd4);
        end_FPGA = 1'b0;
        press_seq(3'd4, 3'd4, 3'd4, 3'd4);
        end_User = 1'b1; end_time = 1'b1; win = 1'b1; tick(3'd5);
        end_User = 1'b0; end_time = 1'b0;
        tick(3'd7);
        tick(3'd7);
        win = 1'b0;
        press_seq(3'd7, 3'd0, 3'd1, 3'd1);

        // timeout alone in PLAY goes straight to RESULT
        press_seq(3'd1, 3'd2, 3'd3, 3'd3);
        end_FPGA = 1'b1; tick(3'd4);
        end_FPGA = 1'b0;
        end_time = 1'b1; tick(3'd7);
        end_time = 1'b0;
        tick(3'd7);
        press_seq(3'd7, 3'd0, 3'd1, 3'd1);

        // mismatch in CHECK ends the game
        press_seq(3'd1, 3'd2, 3'd3, 3'd3);
        end_FPGA = 1'b1; tick(3'd4);
        end_FPGA = 1'b0;
        end_User = 1'b1; match = 1'b0; tick(3'd5);
        end_User = 1'b0;
        tick(3'd7);
        press_seq(3'd7, 3'd0, 3'd1, 3'd1);

        // reset during SEQ abandons the round at the next edge
        press_seq(3'd1, 3'd2, 3'd3, 3'd3);
        reset = 1'b0;
        tick(3'd0);
        tick(3'd0);
        reset = 1'b1;
        tick(3'd1);
        tick(3'd1);

        // let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLOCK_50);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
